// File: rtl/controlador_bcd_if.sv
// Start/result bus of the binary-to-BCD converter.
// Signal names follow the block's external naming.
interface controlador_bcd_if #(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 3
);
    logic                   inicio;
    logic [ANCHO-1:0]       entradaBinaria;
    logic [4*DIGITOS-1:0]   salidaBCD;
    logic                   ocupado;
    logic                   listo;

    modport master (
        output inicio,
        output entradaBinaria,
        input  salidaBCD,
        input  ocupado,
        input  listo
    );

    modport slave (
        input  inicio,
        input  entradaBinaria,
        output salidaBCD,
        output ocupado,
        output listo
    );
endinterface

// File: rtl/controlador_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Optional overflow flag and saturation: define CONTROLADOR_BCD_ERROR_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// REPOSO   | idle, waiting for inicio
// DESPLAZA | add-3 then shift, ANCHO cycles
// LISTO    | one cycle, listo=1, new result already on salidaBCD
module controlador_bcd #(
    parameter int ANCHO   = 8,
    parameter int DIGITOS = 3
) (
    input  logic clk,
    input  logic rst_n,
`ifdef CONTROLADOR_BCD_ERROR_EN
    output logic error,
`endif
    controlador_bcd_if.slave bus
);
    localparam int          WB     = 4*DIGITOS + 4;
    localparam int          CW     = $clog2(ANCHO + 1);
    localparam logic [31:0] LIMITE = 32'(10**DIGITOS - 1);

    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        DESPLAZA = 2'b01,
        LISTO    = 2'b10
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [ANCHO-1:0]       bin_q, bin_d;
    logic [WB-1:0]          bcd_q, bcd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [4*DIGITOS-1:0]   salida_q, salida_d;
    logic [WB-1:0]          ajustado;
    logic [WB-1:0]          bcd_sig;
`ifdef CONTROLADOR_BCD_ERROR_EN
    logic                   ovf_q, ovf_d;
    logic                   error_q, error_d;
`endif

    // The extra top digit absorbs the carry so the kept digits stay exact.
    always_comb begin
        ajustado = bcd_q;
        for (int i = 0; i <= DIGITOS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                ajustado[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_sig = {ajustado[WB-2:0], bin_q[ANCHO-1]};
    end

    always_comb begin
        estado_d = estado_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        salida_d = salida_q;
`ifdef CONTROLADOR_BCD_ERROR_EN
        ovf_d    = ovf_q;
        error_d  = error_q;
`endif
        case (estado_q)
            REPOSO: begin
                if (bus.inicio) begin
                    bin_d    = bus.entradaBinaria;
                    bcd_d    = '0;
                    cnt_d    = CW'(ANCHO);
                    estado_d = DESPLAZA;
`ifdef CONTROLADOR_BCD_ERROR_EN
                    ovf_d    = 32'(bus.entradaBinaria) > LIMITE;
`endif
                end
            end
            DESPLAZA: begin
                bcd_d = bcd_sig;
                bin_d = {bin_q[ANCHO-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                // Result is published on the last shift so it is valid during LISTO.
                if (cnt_q == CW'(1)) begin
                    estado_d = LISTO;
`ifdef CONTROLADOR_BCD_ERROR_EN
                    error_d  = ovf_q;
                    salida_d = ovf_q ? {DIGITOS{4'h9}} : bcd_sig[4*DIGITOS-1:0];
`else
                    salida_d = bcd_sig[4*DIGITOS-1:0];
`endif
                end
            end
            LISTO:   estado_d = REPOSO;
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            salida_q <= '0;
`ifdef CONTROLADOR_BCD_ERROR_EN
            ovf_q    <= 1'b0;
            error_q  <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            salida_q <= salida_d;
`ifdef CONTROLADOR_BCD_ERROR_EN
            ovf_q    <= ovf_d;
            error_q  <= error_d;
`endif
        end
    end

    assign bus.salidaBCD = salida_q;
    assign bus.ocupado   = (estado_q != REPOSO);
    assign bus.listo     = (estado_q == LISTO);
`ifdef CONTROLADOR_BCD_ERROR_EN
    assign error         = error_q;
`endif

endmodule
